ifetch_pc_unit: RTL
===================

Name: ifetch_pc_unit

Overview:
- Fetch stage that directly feeds the next-PC unit.
- Owns the architectural PC register and fetches one instruction at a time from instruction memory over a req/gnt/rvalid handshake.
- Presents the instruction to the core with a valid/ready handshake.
- When the core accepts the instruction, latches the next-PC unit's `npc` as the new PC. Detects misaligned targets and memory timeouts.

Parameters:
- RESET_PC, 32'h1C00_0000, PC loaded on reset.
- MAX_WAIT, 255, max cycles per FETCH or WAIT state before timeout (8-bit counter, 1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- pc  out  32  current instruction PC, to next-PC unit and core
- npc  in  32  next PC from next-PC unit, valid when inst_ready=1
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  instruction data valid
- imem_rdata  in  32  instruction word
- inst  out  32  fetched instruction (registered)
- inst_valid  out  1  inst/pc valid to core
- inst_ready  in  1  core commits instruction this cycle
- err_adef  out  1  sticky: misaligned fetch target
- err_timeout  out  1  sticky: memory did not respond
- fetch_cnt  out  32  count of instructions accepted by core

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0.
  - fetch_cnt=0, err_adef=0, err_timeout=0, wait counter=0.
  - Reset mid-operation abandons any outstanding fetch. Memory shares rst_n.
- Outputs:
  - imem_req=1 only in FETCH.
  - inst_valid=1 only in ISSUE.
  - imem_addr=pc at all times.
- IDLE → FETCH unconditionally. The first request is asserted in the cycle after reset deasserts.
- FETCH:
  - Hold imem_req/imem_addr stable until imem_gnt=1, then → WAIT with counter cleared.
  - imem_rvalid in FETCH is ignored.
- WAIT:
  - On imem_rvalid=1: inst<=imem_rdata, → ISSUE.
  - imem_gnt is ignored.
- ISSUE:
  - Hold inst_valid, inst and pc stable until inst_ready=1.
  - On accept: pc<=npc and fetch_cnt<=fetch_cnt+1 (wraps at 2^32).
  - If npc[1:0]!=2'b00: err_adef<=1, → ERR (pc still updated, for debug). Otherwise → FETCH.
- ERR:
  - Terminal; all outputs are held and handshakes are ignored.
  - Only reset exits.
- Timeout:
  - The counter increments each cycle spent in FETCH or WAIT and clears on every state change.
  - If it reaches MAX_WAIT while still in that state: err_timeout<=1, → ERR.
  - A gnt/rvalid arriving in the same cycle the count reaches MAX_WAIT wins; no error is raised.
- Minimum throughput: 3 cycles per instruction (FETCH with gnt → WAIT with rvalid → ISSUE with ready).
- npc is sampled only in the ISSUE cycle where inst_ready=1. Its value at any other time is don't-care.

Decomposition:
- Shared package `ifetch_pkg` holds:
  - state enum {IDLE, FETCH, WAIT, ISSUE, ERR}.
  - default RESET_PC constant.
  - the next-PC unit's npc_op encodings (PC4=0, BRC=1, JMP=2, PC4_ADD=3), so fetch, decode and next-PC share one definition.
- One sub-module, `fetch_timer`:
  - 8-bit counter with clear/enable inputs and an `expired` output, compared against MAX_WAIT.
- The FSM, PC register and counters stay in ifetch_pc_unit.

Test Plan:
- Reset then zero-wait memory (gnt=1, rvalid 1 cycle after gnt), npc=pc+4, ready=1:
  - Addresses 1C00_0000, 1C00_0004, 1C00_0008 each issue 3 cycles apart.
  - fetch_cnt=3 after the third accept.
- Back-pressure: inst_ready=0 for 5 cycles in ISSUE:
  - inst, pc and inst_valid stay stable.
  - No new imem_req.
  - pc updates only on the ready cycle.
- Branch: at pc=1C00_0010, npc=1C00_0040 on accept:
  - Next imem_addr=1C00_0040.
  - fetch_cnt increments once.
- Misaligned target: npc=1C00_0042 on accept:
  - err_adef=1, state ERR.
  - imem_req stays 0 thereafter until rst_n=0.
- Timeout: gnt given, rvalid withheld:
  - err_timeout=1 after exactly MAX_WAIT (255) WAIT cycles.
  - With rvalid on cycle 255, no error is raised.
- Reset asserted in WAIT, then a stale rvalid during IDLE/FETCH:
  - The stale rvalid is ignored.
  - pc=1C00_0000, fetch_cnt=0, errors cleared.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared fetch/next-PC definitions: fetch FSM states, reset PC and npc_op encodings.
package ifetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1C00_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    ERR   = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    NPC_PC4     = 2'd0,
    NPC_BRC     = 2'd1,
    NPC_JMP     = 2'd2,
    NPC_PC4_ADD = 2'd3
  } npc_op_e;

  function automatic logic pc_aligned(input logic [1:0] pc_lsb);
    return pc_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_pc_unit_fetch_timer.sv
// Per-state wait counter: counts cycles while enabled, expired flags the cycle the count reaches MAX_WAIT.
// Clear has priority over enable so every state change restarts the count from zero.
module fetch_timer #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Combinational so a gnt/rvalid in the same cycle can still steer the FSM away from ERR.
  assign expired_o = en_i && ((cnt_q + 8'd1) == LIMIT);

endmodule

// File: rtl/ifetch_pc_unit.sv
// Fetch stage owning the PC: one outstanding req/gnt/rvalid fetch, valid/ready issue, 3 cycles/instr minimum.
// Core back-pressure holds ISSUE; misaligned npc or memory timeout parks the unit in ERR until reset.
module ifetch_pc_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        err_adef,
  output logic        err_timeout,
  output logic [31:0] fetch_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  fetch_cnt_q, fetch_cnt_d;
  logic         err_adef_q, err_adef_d;
  logic         err_timeout_q, err_timeout_d;
  logic         timer_en, timer_clr, timer_expired;

  assign timer_en  = (state_q == FETCH) || (state_q == WAIT);
  assign timer_clr = (state_d != state_q);

  fetch_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_fetch_timer (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expired_o(timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    fetch_cnt_d   = fetch_cnt_q;
    err_adef_d    = err_adef_q;
    err_timeout_d = err_timeout_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_gnt) begin
          state_d = WAIT;
        end else if (timer_expired) begin
          err_timeout_d = 1'b1;
          state_d       = ERR;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          state_d = ISSUE;
        end else if (timer_expired) begin
          err_timeout_d = 1'b1;
          state_d       = ERR;
        end
      end
      ISSUE: begin
        if (inst_ready) begin
          // PC follows npc even when misaligned so the bad target is visible for debug.
          pc_d        = npc;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          if (pc_aligned(npc[1:0])) begin
            state_d = FETCH;
          end else begin
            err_adef_d = 1'b1;
            state_d    = ERR;
          end
        end
      end
      ERR: state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inst_q        <= 32'd0;
      fetch_cnt_q   <= 32'd0;
      err_adef_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      fetch_cnt_q   <= fetch_cnt_d;
      err_adef_q    <= err_adef_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == FETCH);
  assign inst        = inst_q;
  assign inst_valid  = (state_q == ISSUE);
  assign err_adef    = err_adef_q;
  assign err_timeout = err_timeout_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule
